// File: rtl/pipelined_adder.sv
// pipelined_adder: NBIT-wide add/subtract split into STAGES
// carry-pipelined chunks with a valid/ready handshake per stage.
module pipelined_adder #(
  parameter int NBIT   = 32,
  parameter int STAGES = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [NBIT-1:0] a,
  input  logic [NBIT-1:0] b,
  input  logic            sub,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [NBIT-1:0] s,
  output logic            cout,
  output logic            ovf
);

  if ((STAGES < 1) || ((NBIT % STAGES) != 0)) begin : g_bad
    $error("pipelined_adder: NBIT must be a multiple of STAGES >= 1");
  end

  localparam int CW = NBIT / STAGES;
  localparam int L  = STAGES - 1;

  logic [NBIT-1:0] w_bx;

  assign w_bx = sub ? ~b : b;

  // Stage k adds chunk k; upper operand chunks ride along shrinking.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = (k + 1) * CW;

    logic          w_vin;
    logic          w_cin;
    logic          w_nrdy;
    logic          w_rdy;
    logic          w_ld;
    logic [CW-1:0] w_ac;
    logic [CW-1:0] w_bc;
    logic [CW:0]   w_sum;
    logic [RW-1:0] w_rnx;

    logic          r_vld;
    logic          r_cy;
    logic [RW-1:0] r_res;

    if (k == 0) begin : g_src
      assign w_vin = in_valid;
      assign w_cin = sub;
      assign w_ac  = a[CW-1:0];
      assign w_bc  = w_bx[CW-1:0];
      assign w_rnx = w_sum[CW-1:0];
    end else begin : g_src
      assign w_vin = g_st[k-1].r_vld;
      assign w_cin = g_st[k-1].r_cy;
      assign w_ac  = g_st[k-1].g_fwd.r_a[CW-1:0];
      assign w_bc  = g_st[k-1].g_fwd.r_b[CW-1:0];
      assign w_rnx = {w_sum[CW-1:0], g_st[k-1].r_res};
    end

    if (k == L) begin : g_dn
      assign w_nrdy = out_ready;
    end else begin : g_dn
      assign w_nrdy = g_st[k+1].w_rdy;
    end

    assign w_rdy = !r_vld || w_nrdy;
    assign w_ld  = w_vin && w_rdy;
    assign w_sum = {1'b0, w_ac} + {1'b0, w_bc}
                 + {{CW{1'b0}}, w_cin};

    always_ff @(posedge clk) begin
      if (reset) begin
        r_vld <= 1'b0;
        r_cy  <= 1'b0;
        r_res <= '0;
      end else begin
        if (w_rdy) begin
          r_vld <= w_vin;
        end
        if (w_ld) begin
          r_cy  <= w_sum[CW];
          r_res <= w_rnx;
        end
      end
    end

    if (k < L) begin : g_fwd
      localparam int UW = NBIT - RW;

      logic [UW-1:0] w_au;
      logic [UW-1:0] w_bu;
      logic [UW-1:0] r_a;
      logic [UW-1:0] r_b;

      if (k == 0) begin : g_u
        assign w_au = a[NBIT-1:CW];
        assign w_bu = w_bx[NBIT-1:CW];
      end else begin : g_u
        assign w_au = g_st[k-1].g_fwd.r_a[NBIT-k*CW-1:CW];
        assign w_bu = g_st[k-1].g_fwd.r_b[NBIT-k*CW-1:CW];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_ld) begin
          r_a <= w_au;
          r_b <= w_bu;
        end
      end
    end else begin : g_last
      logic r_ovf;

      always_ff @(posedge clk) begin
        if (reset) begin
          r_ovf <= 1'b0;
        end else if (w_ld) begin
          r_ovf <= (w_ac[CW-1] == w_bc[CW-1])
                && (w_sum[CW-1] != w_ac[CW-1]);
        end
      end
    end
  end

  assign in_ready  = g_st[0].w_rdy;
  assign out_valid = g_st[L].r_vld;
  assign s         = g_st[L].r_res;
  assign cout      = g_st[L].r_cy;
  assign ovf       = g_st[L].g_last.r_ovf;

endmodule
